// File: rtl/div_rem_sequencer.sv
// Multi-cycle signed divide/remainder sequencer for the EX stage.
// Runs a restoring divider one quotient bit per cycle. The pipeline is held on Stall while
// the op runs, and the answer is presented on Result with a single-cycle Valid pulse.
module div_rem_sequencer #(
  parameter int unsigned WIDTH    = 32,
  parameter logic [3:0]  CTRL_DIV = 4'b0110,
  parameter logic [3:0]  CTRL_REM = 4'b1010
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  output logic             Stall,
  output logic             Valid,
  output logic [WIDTH-1:0] Result,
  output logic             DivZero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MinNeg  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] AllOnes = '1;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e           state_q, state_d;
  logic             op_rem_q, op_rem_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [WIDTH-1:0] abs_b_q, abs_b_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             divzero_q, divzero_d;

  logic             accept;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   rem_shift, trial;
  logic [WIDTH-1:0] quo_signed, rem_signed;

  // Operand magnitudes; |MinNeg| wraps to itself, which is 2^(WIDTH-1) read as unsigned.
  assign abs_a = A[WIDTH-1] ? -A : A;
  assign abs_b = B[WIDTH-1] ? -B : B;

  assign accept = (state_q == StIdle) & Start &
                  ((ALUControl == CTRL_DIV) | (ALUControl == CTRL_REM)) & ~Flush;

  // One restoring step: shift {rem,quo} left, then trial-subtract the divisor magnitude.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, abs_b_q};

  assign quo_signed = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
  assign rem_signed = sign_a_q ? -rem_q : rem_q;

  assign Stall   = accept | (state_q == StCalc) | (state_q == StFix);
  assign Valid   = (state_q == StDone);
  assign Result  = result_q;
  assign DivZero = divzero_q;

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    op_rem_d  = op_rem_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    abs_b_d   = abs_b_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    divzero_d = divzero_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_rem_d = (ALUControl == CTRL_REM);
          sign_a_d = A[WIDTH-1];
          sign_b_d = B[WIDTH-1];
          abs_b_d  = abs_b;
          if (B == '0) begin
            result_d  = (ALUControl == CTRL_REM) ? A : AllOnes;
            divzero_d = 1'b1;
            state_d   = StDone;
          end else if ((A == MinNeg) && (B == AllOnes)) begin
            result_d  = (ALUControl == CTRL_REM) ? '0 : MinNeg;
            divzero_d = 1'b0;
            state_d   = StDone;
          end else begin
            rem_d   = '0;
            quo_d   = abs_a;
            cnt_d   = CntW'(WIDTH);
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (Flush) begin
          state_d = StIdle;
        end else begin
          if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = rem_shift[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) state_d = StFix;
        end
      end
      StFix: begin
        if (Flush) begin
          state_d = StIdle;
        end else begin
          result_d  = op_rem_q ? rem_signed : quo_signed;
          divzero_d = 1'b0;
          state_d   = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      op_rem_q  <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      abs_b_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_rem_q  <= op_rem_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      abs_b_q   <= abs_b_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      divzero_q <= divzero_d;
    end
  end

endmodule

// File: tb/tb_div_rem_sequencer.sv
// Self-checking bench for div_rem_sequencer: a cycle-level latency/result model checked every
// cycle, plus directed ops with hand-computed literal expectations.
module tb_div_rem_sequencer;

  localparam logic [3:0] DIV = 4'b0110;
  localparam logic [3:0] REM = 4'b1010;

  logic        clk;
  logic        rst;
  logic        Start;
  logic [3:0]  ALUControl;
  logic [31:0] A;
  logic [31:0] B;
  logic        Flush;
  logic        Stall;
  logic        Valid;
  logic [31:0] Result;
  logic        DivZero;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 0;

  // Model state: m_k counts cycles since accept (0 = idle); Valid is due when m_k == m_lat.
  int          m_k   = 0;
  int          m_lat = 0;
  logic [31:0] m_res = '0;
  logic        m_dz  = 1'b0;
  logic [31:0] m_pres;
  logic        m_pdz;

  div_rem_sequencer #(
    .WIDTH    (32),
    .CTRL_DIV (DIV),
    .CTRL_REM (REM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Start      (Start),
    .ALUControl (ALUControl),
    .A          (A),
    .B          (B),
    .Flush      (Flush),
    .Stall      (Stall),
    .Valid      (Valid),
    .Result     (Result),
    .DivZero    (DivZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Architectural answer for one op, straight from the RISC-V signed divide rules.
  function automatic void model_op(input logic [3:0] c, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] r,
                                   output logic dz, output int lat);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      r = (c == REM) ? a : 32'hFFFF_FFFF;
      dz = 1'b1;
      lat = 1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = (c == REM) ? 32'd0 : 32'h8000_0000;
      dz = 1'b0;
      lat = 1;
    end else begin
      r = (c == REM) ? sa % sb : sa / sb;
      dz = 1'b0;
      lat = 34;
    end
  endfunction

  function automatic bit model_accept();
    return Start && (ALUControl == DIV || ALUControl == REM) && !Flush;
  endfunction

  // Model update on each rising edge (inputs change only 1 time unit after the edge).
  always @(posedge clk) begin
    if (rst) begin
      m_k = 0;
      m_res = '0;
      m_dz = 1'b0;
    end else if (m_k != 0 && m_k == m_lat) begin
      m_k = 0;
    end else if (m_k != 0) begin
      if (Flush) begin
        m_k = 0;
      end else begin
        m_k++;
        if (m_k == m_lat) begin
          m_res = m_pres;
          m_dz = m_pdz;
        end
      end
    end else if (model_accept()) begin
      model_op(ALUControl, A, B, m_pres, m_pdz, m_lat);
      m_k = 1;
      if (m_lat == 1) begin
        m_res = m_pres;
        m_dz = m_pdz;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic exp_stall, exp_valid;
      exp_stall = (m_k == 0) ? model_accept() : (m_k < m_lat);
      exp_valid = (m_k != 0) && (m_k == m_lat);
      check("cyc_stall", 32'(Stall), 32'(exp_stall));
      check("cyc_valid", 32'(Valid), 32'(exp_valid));
      check("cyc_result", Result, m_res);
      check("cyc_divzero", 32'(DivZero), 32'(m_dz));
    end
  end

  // Issue one op from posedge+1, wait (bounded) for Valid, and check literal expectations.
  task automatic do_op(input string name, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input logic exp_dz,
                       input int exp_lat);
    int n;
    int stalls;
    Start = 1'b1;
    ALUControl = c;
    A = a;
    B = b;
    @(negedge clk);
    check({name, "_accept_stall"}, 32'(Stall), 32'd1);
    @(posedge clk);
    #1 Start = 1'b0;
    n = 1;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (Valid || n > 60) break;
      if (Stall) stalls++;
      @(posedge clk);
      #1 n++;
    end
    check({name, "_latency"}, 32'(n), 32'(exp_lat));
    check({name, "_stall_cycles"}, 32'(stalls), 32'(exp_lat - 1));
    check({name, "_result"}, Result, exp_res);
    check({name, "_divzero"}, 32'(DivZero), 32'(exp_dz));
    @(posedge clk);
    #1;
  endtask

  // Start a DIV 15/5 and interrupt it at CALC cycle 10 with Flush or rst.
  task automatic abort_op(input bit use_rst, input logic [31:0] exp_res);
    int valids;
    Start = 1'b1;
    ALUControl = DIV;
    A = 32'd15;
    B = 32'd5;
    @(posedge clk);
    #1 Start = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    if (use_rst) rst = 1'b1;
    else Flush = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    Flush = 1'b0;
    @(negedge clk);
    check(use_rst ? "rst_abort_stall" : "flush_abort_stall", 32'(Stall), 32'd0);
    check(use_rst ? "rst_abort_result" : "flush_abort_result", Result, exp_res);
    valids = 0;
    repeat (40) begin
      @(negedge clk);
      if (Valid) valids++;
    end
    check(use_rst ? "rst_abort_no_valid" : "flush_abort_no_valid", 32'(valids), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] pr;
    logic        pdz;
    int          plat;
    int          valids;

    // Pin the model itself against hand-worked answers.
    model_op(DIV, 32'hFFFF_FFEF, 32'd7, pr, pdz, plat);
    check("model_div_m17_7", pr, 32'hFFFF_FFFE);
    model_op(REM, 32'hFFFF_FFEF, 32'd7, pr, pdz, plat);
    check("model_rem_m17_7", pr, 32'hFFFF_FFFD);
    model_op(DIV, 32'd5, 32'd0, pr, pdz, plat);
    check("model_div0_lat", 32'(plat), 32'd1);
    model_op(DIV, 32'd15, 32'd5, pr, pdz, plat);
    check("model_norm_lat", 32'(plat), 32'd34);

    rst = 1'b1;
    Start = 1'b0;
    ALUControl = 4'b0000;
    A = '0;
    B = '0;
    Flush = 1'b0;
    @(posedge clk);
    #1 cmp_en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;

    // Unsupported op code is ignored.
    A = 32'd15;
    B = 32'd5;
    ALUControl = 4'b0000;
    Start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("idle_stall", 32'(Stall), 32'd0);
      check("idle_valid", 32'(Valid), 32'd0);
      check("idle_result", Result, 32'd0);
      @(posedge clk);
      #1;
    end
    Start = 1'b0;

    do_op("div_15_5", DIV, 32'd15, 32'd5, 32'd3, 1'b0, 34);
    do_op("rem_15_5", REM, 32'd15, 32'd5, 32'd0, 1'b0, 34);
    do_op("div_3_5", DIV, 32'd3, 32'd5, 32'd0, 1'b0, 34);
    do_op("rem_3_5", REM, 32'd3, 32'd5, 32'd3, 1'b0, 34);
    do_op("div_m17_7", DIV, 32'hFFFF_FFEF, 32'd7, 32'hFFFF_FFFE, 1'b0, 34);
    do_op("rem_m17_7", REM, 32'hFFFF_FFEF, 32'd7, 32'hFFFF_FFFD, 1'b0, 34);
    do_op("div_m150_m50", DIV, 32'hFFFF_FF6A, 32'hFFFF_FFCE, 32'd3, 1'b0, 34);
    do_op("div_min_7", DIV, 32'h8000_0000, 32'd7, 32'hEDB6_DB6E, 1'b0, 34);
    do_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
    do_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);
    do_op("div_by0", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);
    do_op("rem_by0", REM, 32'd5, 32'd0, 32'd5, 1'b1, 1);

    abort_op(1'b0, 32'd5);
    abort_op(1'b1, 32'd0);

    // Flush alongside Start in IDLE blocks the accept.
    Start = 1'b1;
    Flush = 1'b1;
    ALUControl = DIV;
    A = 32'd15;
    B = 32'd5;
    @(negedge clk);
    check("flush_start_stall", 32'(Stall), 32'd0);
    @(posedge clk);
    #1 Flush = 1'b0;
    Start = 1'b0;
    @(negedge clk);
    check("flush_start_no_op", 32'(Stall), 32'd0);
    @(posedge clk);
    #1;

    // Start held high: DONE ignores it, the following IDLE cycle accepts again.
    Start = 1'b1;
    ALUControl = DIV;
    A = 32'd7;
    B = 32'd0;
    valids = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (Valid) valids++;
      @(posedge clk);
      #1;
    end
    Start = 1'b0;
    check("back_to_back_valids", 32'(valids), 32'd3);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/div_rem_sequencer.md
Name: div_rem_sequencer

Overview:
- Multi-cycle controller for signed RISC-V division (ALUControl 4'b0110) and remainder (ALUControl 4'b1010).
- Sits beside the single-cycle ALU in EX and owns an iterative restoring divider datapath.
- Holds the pipeline via Stall until the quotient or remainder is ready, then presents it on Result with a one-cycle Valid pulse.
- Replaces the combinational divide path so that EX timing no longer includes a 32-bit divider.

Parameters:
- WIDTH, 32, operand and result width in bits; iteration count equals WIDTH.
- CTRL_DIV, 4'b0110, ALUControl code selecting signed quotient.
- CTRL_REM, 4'b1010, ALUControl code selecting signed remainder.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- Start  input  1  EX holds a candidate op this cycle.
- ALUControl  input  4  op code; only CTRL_DIV and CTRL_REM are accepted.
- A  input  WIDTH  dividend, two's complement.
- B  input  WIDTH  divisor, two's complement.
- Flush  input  1  kill the in-flight op (branch or flush from hazard unit).
- Stall  output  1  freeze IF/ID/EX while high.
- Valid  output  1  Result is valid; one-cycle pulse.
- Result  output  WIDTH  quotient or remainder.
- DivZero  output  1  the last completed op had B==0; held with Result.

Behaviour:
- Reset and clocking:
  - Synchronous active-high rst on clk.
  - rst forces state=IDLE, Result=0, Valid=0, DivZero=0, iteration counter=0 and internal registers=0.
  - rst mid-operation aborts the op with no Valid pulse.
- States: IDLE, CALC, FIX, DONE.
- Accept rule: accept = (state==IDLE) & Start & (ALUControl==CTRL_DIV | ALUControl==CTRL_REM) & ~Flush.
  - Any other ALUControl value is ignored; the block stays in IDLE.
- IDLE, on accept, capture op, sign(A), sign(B), |A|, |B|. Then:
  - If B==0: Result = CTRL_DIV ? all-ones : A, DivZero=1, go to DONE.
  - If A==0x80..0 and B==all-ones (signed overflow): Result = CTRL_DIV ? 0x80..0 : 0, DivZero=0, go to DONE.
  - Otherwise: remainder reg=0, quotient reg=|A|, counter=WIDTH, go to CALC.
- CALC, one restoring step per cycle:
  - Shift {rem,quo} left by 1; trial = rem - |B|.
  - If trial is non-negative, rem=trial and quotient LSB=1; else quotient LSB=0.
  - Decrement the counter. When the counter goes 1->0, go to FIX.
- FIX:
  - Quotient is negated iff sign(A) XOR sign(B).
  - Remainder takes the sign of A.
  - Register the selected value into Result, DivZero=0, go to DONE.
- DONE: Valid=1 for exactly this cycle; Start is ignored; go to IDLE.
- Stall = (accept & state==IDLE) | state==CALC | state==FIX. Stall is 0 in DONE, so EX retires the op that cycle.
- Latency, counted from the accept edge to the cycle in which Valid is high:
  - Special cases (B==0, overflow): 1 cycle.
  - Normal ops: WIDTH+2 cycles (WIDTH CALC + FIX + DONE), i.e. 34 cycles when WIDTH=32.
- Result and DivZero hold their value after DONE until the next accepted op or rst.
- Flush:
  - Flush in CALC or FIX returns to IDLE next edge with no Valid; Result is unchanged.
  - Flush in DONE has no effect on Valid.
  - Flush together with Start in IDLE means no accept.
- Start in the cycle immediately after DONE is a new op and is accepted normally. The hazard unit guarantees that EX has advanced.
- Arithmetic:
  - All internal magnitudes are WIDTH bits; the trial subtraction is WIDTH+1 bits.
  - |0x80..0| is treated as the unsigned value 2^(WIDTH-1) with no saturation.

Test Plan:
- Reset and idle: rst high 2 cycles, then A=15, B=5, ALUControl=0000, Start=1 -> Stall=0, Valid=0, Result=0 throughout.
- Normal ops, each checking Stall high for 33 cycles and Valid on cycle 34:
  - DIV A=15, B=5 -> Result=3.
  - REM A=15, B=5 -> Result=0.
  - DIV A=3, B=5 -> Result=0.
  - REM A=3, B=5 -> Result=3.
- Signed: A=-17, B=7:
  - DIV -> 0xFFFFFFFE.
  - REM -> 0xFFFFFFFD.
  - A=-150, B=-50 DIV -> 3.
- Divide by zero, A=5, B=0:
  - DIV -> Result=0xFFFFFFFF, DivZero=1, Valid 1 cycle after accept.
  - REM -> Result=5.
- Overflow, A=0x80000000, B=0xFFFFFFFF:
  - DIV -> 0x80000000.
  - REM -> 0.
  - Both with 1-cycle latency and DivZero=0.
- Abort: start DIV 15/5, assert Flush at CALC cycle 10 -> no Valid, Stall low next cycle, Result keeps its prior value. Repeat the scenario with rst at cycle 10 -> Result=0.
